// File: rtl/noop_pkg.sv
// noop_pkg: shared constants for the noop_sim MIPS32 core.
// Holds the MIPS opcode, SPECIAL funct and REGIMM rt encodings, the default reset PC,
// and the ALU operation and writeback-source enumerations.
package noop_pkg;

  localparam logic [31:0] ResetPcDefault = 32'hBFC0_0000;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpRegimm  = 6'h01;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBlez    = 6'h06;
  localparam logic [5:0] OpBgtz    = 6'h07;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0a;
  localparam logic [5:0] OpSltiu   = 6'h0b;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpXori    = 6'h0e;
  localparam logic [5:0] OpLui     = 6'h0f;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSw      = 6'h2b;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  // REGIMM rt codes (instr[20:16])
  localparam logic [4:0] RtBltz = 5'h00;
  localparam logic [4:0] RtBgez = 5'h01;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor,
    AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
  } alu_op_e;

  typedef enum logic [1:0] {WbAlu, WbMem, WbLink} wb_sel_e;

endpackage

// File: rtl/noop_alu.sv
// noop_alu: combinational ALU and barrel shifter for noop_sim.
// Ports:
//   a      - first operand (rs value)
//   b      - second operand (rt value or extended immediate); shifts operate on b
//   shamt  - shift amount (instruction shamt or rs[4:0])
//   op     - operation select
//   result - 32-bit result
module noop_alu
  import noop_pkg::*;
(
  input  logic    [31:0] a,
  input  logic    [31:0] b,
  input  logic    [4:0]  shamt,
  input  alu_op_e        op,
  output logic    [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      AluAdd:  result = a + b;
      AluSub:  result = a - b;
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluXor:  result = a ^ b;
      AluNor:  result = ~(a | b);
      AluSlt:  result = {31'b0, $signed(a) < $signed(b)};
      AluSltu: result = {31'b0, a < b};
      AluSll:  result = b << shamt;
      AluSrl:  result = b >> shamt;
      AluSra:  result = 32'($signed(b) >>> shamt);
      AluLui:  result = {b[15:0], 16'h0000};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/noop_sim.sv
// noop_sim: single-cycle, in-order MIPS32 subset core with one branch delay slot.
// One instruction retires per clock while out of reset; unsupported encodings retire as NOPs.
// Ports:
//   clk                - sole clock, all state on rising edge
//   areset             - asynchronous active-high reset
//   dcm_locked         - clock ready; core held in reset while low
//   io_commit_valid    - an instruction retired at the last rising edge
//   io_commit_pc       - PC of the retired instruction
//   io_commit_instr    - encoding of the retired instruction
//   io_commit_gpr_0..31 - live register file contents (post-writeback)
module noop_sim
  import noop_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = ResetPcDefault,
  parameter int unsigned MEM_WORDS = 4096,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        dcm_locked,
  output logic        io_commit_valid,
  output logic [31:0] io_commit_pc,
  output logic [31:0] io_commit_instr,
  output logic [31:0] io_commit_gpr_0,
  output logic [31:0] io_commit_gpr_1,
  output logic [31:0] io_commit_gpr_2,
  output logic [31:0] io_commit_gpr_3,
  output logic [31:0] io_commit_gpr_4,
  output logic [31:0] io_commit_gpr_5,
  output logic [31:0] io_commit_gpr_6,
  output logic [31:0] io_commit_gpr_7,
  output logic [31:0] io_commit_gpr_8,
  output logic [31:0] io_commit_gpr_9,
  output logic [31:0] io_commit_gpr_10,
  output logic [31:0] io_commit_gpr_11,
  output logic [31:0] io_commit_gpr_12,
  output logic [31:0] io_commit_gpr_13,
  output logic [31:0] io_commit_gpr_14,
  output logic [31:0] io_commit_gpr_15,
  output logic [31:0] io_commit_gpr_16,
  output logic [31:0] io_commit_gpr_17,
  output logic [31:0] io_commit_gpr_18,
  output logic [31:0] io_commit_gpr_19,
  output logic [31:0] io_commit_gpr_20,
  output logic [31:0] io_commit_gpr_21,
  output logic [31:0] io_commit_gpr_22,
  output logic [31:0] io_commit_gpr_23,
  output logic [31:0] io_commit_gpr_24,
  output logic [31:0] io_commit_gpr_25,
  output logic [31:0] io_commit_gpr_26,
  output logic [31:0] io_commit_gpr_27,
  output logic [31:0] io_commit_gpr_28,
  output logic [31:0] io_commit_gpr_29,
  output logic [31:0] io_commit_gpr_30,
  output logic [31:0] io_commit_gpr_31
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  logic rst;
  assign rst = areset | ~dcm_locked;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] gpr_q [32];
  logic [31:0] pc_q, npc_q;
  logic        commit_valid_q;
  logic [31:0] commit_pc_q, commit_instr_q;

  // Fetch and field extraction
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_val, rt_val, imm_sext, imm_zext;

  assign instr    = mem[pc_q[IdxW+1:2]];
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm16    = instr[15:0];
  assign imm26    = instr[25:0];
  assign rs_val   = gpr_q[rs];
  assign rt_val   = gpr_q[rt];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'h0000, imm16};

  // Decode
  alu_op_e     alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_shamt;
  logic        wb_en, mem_we, taken;
  logic [4:0]  wb_addr;
  wb_sel_e     wb_sel;
  logic [31:0] target;

  always_comb begin
    alu_op    = AluAdd;
    alu_a     = rs_val;
    alu_b     = rt_val;
    alu_shamt = shamt;
    wb_en     = 1'b0;
    wb_addr   = rd;
    wb_sel    = WbAlu;
    mem_we    = 1'b0;
    taken     = 1'b0;
    // Branch offsets are relative to the delay-slot PC, which is npc_q.
    target    = npc_q + {imm_sext[29:0], 2'b00};
    case (opcode)
      OpSpecial: begin
        case (funct)
          FnSll:  begin alu_op = AluSll;  wb_en = 1'b1; end
          FnSrl:  begin alu_op = AluSrl;  wb_en = 1'b1; end
          FnSra:  begin alu_op = AluSra;  wb_en = 1'b1; end
          FnSllv: begin alu_op = AluSll;  alu_shamt = rs_val[4:0]; wb_en = 1'b1; end
          FnSrlv: begin alu_op = AluSrl;  alu_shamt = rs_val[4:0]; wb_en = 1'b1; end
          FnSrav: begin alu_op = AluSra;  alu_shamt = rs_val[4:0]; wb_en = 1'b1; end
          FnJr:   begin taken = 1'b1; target = rs_val; end
          FnJalr: begin taken = 1'b1; target = rs_val; wb_en = 1'b1; wb_sel = WbLink; end
          FnAddu: begin alu_op = AluAdd;  wb_en = 1'b1; end
          FnSubu: begin alu_op = AluSub;  wb_en = 1'b1; end
          FnAnd:  begin alu_op = AluAnd;  wb_en = 1'b1; end
          FnOr:   begin alu_op = AluOr;   wb_en = 1'b1; end
          FnXor:  begin alu_op = AluXor;  wb_en = 1'b1; end
          FnNor:  begin alu_op = AluNor;  wb_en = 1'b1; end
          FnSlt:  begin alu_op = AluSlt;  wb_en = 1'b1; end
          FnSltu: begin alu_op = AluSltu; wb_en = 1'b1; end
          default: ;
        endcase
      end
      OpRegimm: begin
        case (rt)
          RtBltz:  taken = rs_val[31];
          RtBgez:  taken = ~rs_val[31];
          default: ;
        endcase
      end
      OpJ:    begin taken = 1'b1; target = {npc_q[31:28], imm26, 2'b00}; end
      OpJal:  begin
        taken   = 1'b1;
        target  = {npc_q[31:28], imm26, 2'b00};
        wb_en   = 1'b1;
        wb_addr = 5'd31;
        wb_sel  = WbLink;
      end
      OpBeq:   taken = (rs_val == rt_val);
      OpBne:   taken = (rs_val != rt_val);
      OpBlez:  taken = rs_val[31] | (rs_val == '0);
      OpBgtz:  taken = ~rs_val[31] & (rs_val != '0);
      OpAddiu: begin alu_b = imm_sext; wb_addr = rt; wb_en = 1'b1; end
      OpSlti:  begin alu_op = AluSlt;  alu_b = imm_sext; wb_addr = rt; wb_en = 1'b1; end
      OpSltiu: begin alu_op = AluSltu; alu_b = imm_sext; wb_addr = rt; wb_en = 1'b1; end
      OpAndi:  begin alu_op = AluAnd;  alu_b = imm_zext; wb_addr = rt; wb_en = 1'b1; end
      OpOri:   begin alu_op = AluOr;   alu_b = imm_zext; wb_addr = rt; wb_en = 1'b1; end
      OpXori:  begin alu_op = AluXor;  alu_b = imm_zext; wb_addr = rt; wb_en = 1'b1; end
      OpLui:   begin alu_op = AluLui;  alu_b = imm_zext; wb_addr = rt; wb_en = 1'b1; end
      OpLw:    begin alu_b = imm_sext; wb_addr = rt; wb_en = 1'b1; wb_sel = WbMem; end
      OpSw:    begin alu_b = imm_sext; mem_we = 1'b1; end
      default: ;
    endcase
  end

  noop_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .shamt  (alu_shamt),
    .op     (alu_op),
    .result (alu_result)
  );

  // Load/store address comes from the ALU adder; upper bits alias.
  logic [31:0] mem_rdata, wb_data;
  assign mem_rdata = mem[alu_result[IdxW+1:2]];

  always_comb begin
    case (wb_sel)
      WbMem:   wb_data = mem_rdata;
      WbLink:  wb_data = pc_q + 32'd8;
      default: wb_data = alu_result;
    endcase
  end

  // Stores are suppressed while reset is asserted so a held-in-reset SW never writes.
  logic mem_we_run;
  assign mem_we_run = mem_we & ~areset & dcm_locked;

  always_ff @(posedge clk) begin
    if (mem_we_run) mem[alu_result[IdxW+1:2]] <= rt_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      npc_q          <= RESET_PC + 32'd4;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_instr_q <= '0;
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else begin
      pc_q           <= npc_q;
      npc_q          <= taken ? target : npc_q + 32'd4;
      commit_valid_q <= 1'b1;
      commit_pc_q    <= pc_q;
      commit_instr_q <= instr;
      if (wb_en && (wb_addr != 5'd0)) gpr_q[wb_addr] <= wb_data;
    end
  end

  assign io_commit_valid  = commit_valid_q;
  assign io_commit_pc     = commit_pc_q;
  assign io_commit_instr  = commit_instr_q;
  assign io_commit_gpr_0  = gpr_q[0];
  assign io_commit_gpr_1  = gpr_q[1];
  assign io_commit_gpr_2  = gpr_q[2];
  assign io_commit_gpr_3  = gpr_q[3];
  assign io_commit_gpr_4  = gpr_q[4];
  assign io_commit_gpr_5  = gpr_q[5];
  assign io_commit_gpr_6  = gpr_q[6];
  assign io_commit_gpr_7  = gpr_q[7];
  assign io_commit_gpr_8  = gpr_q[8];
  assign io_commit_gpr_9  = gpr_q[9];
  assign io_commit_gpr_10 = gpr_q[10];
  assign io_commit_gpr_11 = gpr_q[11];
  assign io_commit_gpr_12 = gpr_q[12];
  assign io_commit_gpr_13 = gpr_q[13];
  assign io_commit_gpr_14 = gpr_q[14];
  assign io_commit_gpr_15 = gpr_q[15];
  assign io_commit_gpr_16 = gpr_q[16];
  assign io_commit_gpr_17 = gpr_q[17];
  assign io_commit_gpr_18 = gpr_q[18];
  assign io_commit_gpr_19 = gpr_q[19];
  assign io_commit_gpr_20 = gpr_q[20];
  assign io_commit_gpr_21 = gpr_q[21];
  assign io_commit_gpr_22 = gpr_q[22];
  assign io_commit_gpr_23 = gpr_q[23];
  assign io_commit_gpr_24 = gpr_q[24];
  assign io_commit_gpr_25 = gpr_q[25];
  assign io_commit_gpr_26 = gpr_q[26];
  assign io_commit_gpr_27 = gpr_q[27];
  assign io_commit_gpr_28 = gpr_q[28];
  assign io_commit_gpr_29 = gpr_q[29];
  assign io_commit_gpr_30 = gpr_q[30];
  assign io_commit_gpr_31 = gpr_q[31];

endmodule

// File: tb/tb_noop_sim.sv
// tb_noop_sim: scoreboard bench for noop_sim. The stimulus process loads a program into the
// RAM, queues the expected commit stream and drives reset; a negedge monitor pops one entry
// per valid commit and checks pc, instr and one selected GPR.
module tb_noop_sim;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        dcm_locked = 1'b1;
  logic        valid;
  logic [31:0] cpc, cinstr;
  logic [31:0] gpr_view [32];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int unsigned gidx;
    logic [31:0] gval;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Word i sits at 0xBFC00000 + 4*i. Words 4,5,10,11 are skipped filler (ADDIU $1,$0,0x7F).
  localparam logic [31:0] Prog [21] = '{
    32'h24010005, 32'h3C021234, 32'h10000003, 32'h34425678,
    32'h2401007F, 32'h2401007F, 32'hAC020010, 32'h8C030010,
    32'h0FF0000C, 32'h2404FFFF, 32'h2401007F, 32'h2401007F,
    32'h0004282B, 32'h0004302A, 32'h00043903, 32'h24000007,
    32'h00234023, 32'h14210005, 32'h00244806, 32'h0BF00013,
    32'hFFFFFFFF
  };

  always #5 clk = ~clk;

  noop_sim dut (
    .clk              (clk),
    .areset           (areset),
    .dcm_locked       (dcm_locked),
    .io_commit_valid  (valid),
    .io_commit_pc     (cpc),
    .io_commit_instr  (cinstr),
    .io_commit_gpr_0  (gpr_view[0]),
    .io_commit_gpr_1  (gpr_view[1]),
    .io_commit_gpr_2  (gpr_view[2]),
    .io_commit_gpr_3  (gpr_view[3]),
    .io_commit_gpr_4  (gpr_view[4]),
    .io_commit_gpr_5  (gpr_view[5]),
    .io_commit_gpr_6  (gpr_view[6]),
    .io_commit_gpr_7  (gpr_view[7]),
    .io_commit_gpr_8  (gpr_view[8]),
    .io_commit_gpr_9  (gpr_view[9]),
    .io_commit_gpr_10 (gpr_view[10]),
    .io_commit_gpr_11 (gpr_view[11]),
    .io_commit_gpr_12 (gpr_view[12]),
    .io_commit_gpr_13 (gpr_view[13]),
    .io_commit_gpr_14 (gpr_view[14]),
    .io_commit_gpr_15 (gpr_view[15]),
    .io_commit_gpr_16 (gpr_view[16]),
    .io_commit_gpr_17 (gpr_view[17]),
    .io_commit_gpr_18 (gpr_view[18]),
    .io_commit_gpr_19 (gpr_view[19]),
    .io_commit_gpr_20 (gpr_view[20]),
    .io_commit_gpr_21 (gpr_view[21]),
    .io_commit_gpr_22 (gpr_view[22]),
    .io_commit_gpr_23 (gpr_view[23]),
    .io_commit_gpr_24 (gpr_view[24]),
    .io_commit_gpr_25 (gpr_view[25]),
    .io_commit_gpr_26 (gpr_view[26]),
    .io_commit_gpr_27 (gpr_view[27]),
    .io_commit_gpr_28 (gpr_view[28]),
    .io_commit_gpr_29 (gpr_view[29]),
    .io_commit_gpr_30 (gpr_view[30]),
    .io_commit_gpr_31 (gpr_view[31])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_commit(input logic [31:0] pc, input logic [31:0] instr,
                               input int unsigned gidx, input logic [31:0] gval);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.gidx = gidx;
    e.gval = gval;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {31'b0, valid}, 32'h0);
    check({tag, "_pc"}, cpc, 32'h0);
    check({tag, "_instr"}, cinstr, 32'h0);
    check({tag, "_gpr2"}, gpr_view[2], 32'h0);
    check({tag, "_gpr31"}, gpr_view[31], 32'h0);
  endtask

  // Monitor: one scoreboard pop per retired instruction.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_commit: got pc %h, no commit required", cpc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("commit_pc", cpc, e.pc);
        check("commit_instr", cinstr, e.instr);
        check($sformatf("gpr_%0d@%h", e.gidx, e.pc), gpr_view[e.gidx], e.gval);
      end
    end
  end

  initial begin
    for (int i = 0; i < 21; i++) dut.mem[i] = Prog[i];
    repeat (2) @(negedge clk);
    check_reset_state("reset");

    // Run 1: straight line, taken BEQ, JAL, ALU ops, BNE not taken, J spin loop.
    expect_commit(32'hBFC00000, 32'h24010005, 1, 32'h00000005);
    expect_commit(32'hBFC00004, 32'h3C021234, 2, 32'h12340000);
    expect_commit(32'hBFC00008, 32'h10000003, 1, 32'h00000005);
    expect_commit(32'hBFC0000C, 32'h34425678, 2, 32'h12345678);
    expect_commit(32'hBFC00018, 32'hAC020010, 2, 32'h12345678);
    expect_commit(32'hBFC0001C, 32'h8C030010, 3, 32'h12345678);
    expect_commit(32'hBFC00020, 32'h0FF0000C, 31, 32'hBFC00028);
    expect_commit(32'hBFC00024, 32'h2404FFFF, 4, 32'hFFFFFFFF);
    expect_commit(32'hBFC00030, 32'h0004282B, 5, 32'h00000001);
    expect_commit(32'hBFC00034, 32'h0004302A, 6, 32'h00000000);
    expect_commit(32'hBFC00038, 32'h00043903, 7, 32'hFFFFFFFF);
    expect_commit(32'hBFC0003C, 32'h24000007, 0, 32'h00000000);
    expect_commit(32'hBFC00040, 32'h00234023, 8, 32'hEDCBA98D);
    expect_commit(32'hBFC00044, 32'h14210005, 1, 32'h00000005);
    expect_commit(32'hBFC00048, 32'h00244806, 9, 32'h07FFFFFF);
    expect_commit(32'hBFC0004C, 32'h0BF00013, 9, 32'h07FFFFFF);
    expect_commit(32'hBFC00050, 32'hFFFFFFFF, 31, 32'hBFC00028);
    expect_commit(32'hBFC0004C, 32'h0BF00013, 8, 32'hEDCBA98D);
    expect_commit(32'hBFC00050, 32'hFFFFFFFF, 4, 32'hFFFFFFFF);
    expect_commit(32'hBFC0004C, 32'h0BF00013, 1, 32'h00000005);
    expect_commit(32'hBFC00050, 32'hFFFFFFFF, 0, 32'h00000000);
    #1 areset = 1'b0;
    repeat (21) @(negedge clk);

    // Clock-ready drop mid-run for three cycles.
    #1 dcm_locked = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_state("dcm_low");
    end

    // Run 2: restart from the reset PC with a cleared register file.
    expect_commit(32'hBFC00000, 32'h24010005, 1, 32'h00000005);
    expect_commit(32'hBFC00004, 32'h3C021234, 2, 32'h12340000);
    expect_commit(32'hBFC00008, 32'h10000003, 3, 32'h00000000);
    #1 dcm_locked = 1'b1;
    repeat (3) @(negedge clk);
    #1 areset = 1'b1;
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
